// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues in-order fetch requests to instruction memory,
// tags each response with the pc it was fetched from, and buffers it for decode.
// A redirect flushes the buffer and drains responses that are still in flight.
module instr_fetch_queue #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr, tag_ptr;
    logic [CNT_W-1:0]  occupancy, outstanding, discard;
    logic [CNT_W-1:0]  outstanding_after_rsp;
    logic [CNT_W:0]    inflight;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    entry_t            fifo_mem [DEPTH];
    entry_t            head;
    logic              rsp_fire, req_fire, push, pop;

    // A response with nothing outstanding (e.g. one left over from before a reset) is ignored.
    assign rsp_fire              = imem_rsp_valid && (outstanding != '0);
    assign outstanding_after_rsp = outstanding - CNT_W'(rsp_fire);
    assign inflight              = {1'b0, occupancy} + {1'b0, outstanding};
    assign req_fire              = imem_req_valid && imem_req_ready;
    assign imem_req_addr         = fetch_addr;

    // Decode sees nothing during a redirect cycle, so no pop can happen alongside the flush.
    assign instr_valid = !reset && !redirect_valid && (occupancy != '0);
    assign pop         = instr_valid && instr_ready;
    assign head        = fifo_mem[rd_ptr];
    assign instr_data  = (occupancy != '0) ? head.data : '0;
    assign instr_pc    = (occupancy != '0) ? head.pc   : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next state, request issue and FIFO push decision.
    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        if (!reset) begin
            if (redirect_valid) begin
                state_d = (outstanding_after_rsp != '0) ? DRAIN : FETCH;
            end else begin
                case (state_q)
                    FETCH: begin
                        // Outstanding requests reserve FIFO slots, so a push can never overflow.
                        imem_req_valid = inflight < (CNT_W+1)'(DEPTH);
                        push           = rsp_fire;
                    end
                    DRAIN: begin
                        if (rsp_fire && discard == CNT_W'(1)) state_d = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
        end
    end

    // Counters, pointers and fetch/tag addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr  <= '0;
            tag_ptr     <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight becomes garbage; a response landing now is dropped.
            fetch_addr  <= redirect_addr;
            tag_ptr     <= redirect_addr;
            occupancy   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding_after_rsp;
            discard     <= outstanding_after_rsp;
        end else begin
            if (req_fire) fetch_addr <= fetch_addr + ADDR_W'(1);
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                tag_ptr <= tag_ptr + ADDR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
            if (state_q == DRAIN && rsp_fire) discard <= discard - CNT_W'(1);
        end
    end

    // FIFO storage: data paired with the pc it was fetched from.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{data: imem_rsp_data, pc: tag_ptr};
    end

    // Buffered plus in-flight fetches never exceed the FIFO capacity.
    assert property (@(posedge clk) disable iff (reset) inflight <= (CNT_W+1)'(DEPTH));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a vector table covers streaming, back-pressure,
// address wrap and redirect-with-response; hand sequences cover drain and reset corners.
module tb_instr_fetch_queue;
    logic       clk;
    logic       reset;
    logic       redirect_valid;
    logic [9:0] redirect_addr;
    logic       imem_req_valid;
    logic [9:0] imem_req_addr;
    logic       imem_req_ready;
    logic       imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic       instr_valid;
    logic [15:0] instr_data;
    logic [9:0] instr_pc;
    logic       instr_ready;

    int n_chk  = 0;
    int n_fail = 0;

    // Addresses accepted by the memory model, answered in order one per cycle when enabled.
    logic [9:0] pend[$];

    typedef struct {
        logic       redir;
        logic [9:0] raddr;
        logic       rrdy;
        logic       rsp_en;
        logic       irdy;
        logic       exp_rv;
        logic [9:0] exp_ra;
        logic       exp_iv;
        logic [9:0] exp_pc;
    } vec_t;

    vec_t vt[19];

    instr_fetch_queue #(.ADDR_W(10), .DATA_W(16), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_data(input logic [9:0] a);
        return 16'hC3A5 ^ {6'd0, a};
    endfunction

    function automatic vec_t mk(input logic redir, input logic [9:0] raddr, input logic rrdy,
                                input logic rsp_en, input logic irdy, input logic erv,
                                input logic [9:0] era, input logic eiv, input logic [9:0] epc);
        vec_t v;
        v.redir = redir; v.raddr = raddr; v.rrdy = rrdy; v.rsp_en = rsp_en; v.irdy = irdy;
        v.exp_rv = erv; v.exp_ra = era; v.exp_iv = eiv; v.exp_pc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic redir, input logic [9:0] raddr,
                         input logic rrdy, input logic rsp_en, input logic irdy);
        reset          = rst;
        redirect_valid = redir;
        redirect_addr  = raddr;
        imem_req_ready = rrdy;
        instr_ready    = irdy;
        imem_rsp_valid = rsp_en && (pend.size() != 0);
        imem_rsp_data  = '0;
        if (imem_rsp_valid) imem_rsp_data = mem_data(pend[0]);
    endtask

    // Advance one clock; update the memory model from handshakes seen before the edge.
    task automatic tick();
        logic       rf, sf;
        logic [9:0] ra;
        rf = imem_req_valid && imem_req_ready;
        ra = imem_req_addr;
        sf = imem_rsp_valid;
        @(posedge clk);
        #1;
        if (sf && pend.size() != 0) pend.delete(0);
        if (rf) pend.push_back(ra);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        drive(1'b0, v.redir, v.raddr, v.rrdy, v.rsp_en, v.irdy);
        #4;
        chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(v.exp_rv));
        chk({tag, " req_addr"}, 32'(imem_req_addr), 32'(v.exp_ra));
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(v.exp_iv));
        if (v.exp_iv) begin
            chk({tag, " instr_pc"}, 32'(instr_pc), 32'(v.exp_pc));
            chk({tag, " instr_data"}, 32'(instr_data), 32'(mem_data(v.exp_pc)));
        end
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, " req_addr"}, 32'(imem_req_addr), 32'd0);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, " instr_data"}, 32'(instr_data), 32'd0);
        chk({tag, " instr_pc"}, 32'(instr_pc), 32'd0);
    endtask

    task automatic do_reset();
        pend.delete();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        // Fresh start: decode stalled so exactly four fetches go out, then released for
        // one-per-cycle streaming; redirect to 1022 lands with a response and a pending pop;
        // the new stream wraps 1022, 1023, 0.
        //          redir raddr  rrdy rsp irdy | rv  ra     iv  pc
        vt[0]  = mk(0, 10'd0,    1, 1, 0,      1, 10'd0,    0, 10'd0);
        vt[1]  = mk(0, 10'd0,    1, 1, 0,      1, 10'd1,    0, 10'd0);
        vt[2]  = mk(0, 10'd0,    1, 1, 0,      1, 10'd2,    1, 10'd0);
        vt[3]  = mk(0, 10'd0,    1, 1, 0,      1, 10'd3,    1, 10'd0);
        vt[4]  = mk(0, 10'd0,    1, 1, 0,      0, 10'd4,    1, 10'd0);
        vt[5]  = mk(0, 10'd0,    1, 1, 0,      0, 10'd4,    1, 10'd0);
        vt[6]  = mk(0, 10'd0,    1, 1, 1,      0, 10'd4,    1, 10'd0);
        vt[7]  = mk(0, 10'd0,    1, 1, 1,      1, 10'd4,    1, 10'd1);
        vt[8]  = mk(0, 10'd0,    1, 1, 1,      1, 10'd5,    1, 10'd2);
        vt[9]  = mk(0, 10'd0,    1, 1, 1,      1, 10'd6,    1, 10'd3);
        vt[10] = mk(0, 10'd0,    1, 1, 1,      1, 10'd7,    1, 10'd4);
        vt[11] = mk(0, 10'd0,    1, 1, 1,      1, 10'd8,    1, 10'd5);
        vt[12] = mk(0, 10'd0,    1, 1, 1,      1, 10'd9,    1, 10'd6);
        vt[13] = mk(1, 10'd1022, 1, 1, 1,      0, 10'd10,   0, 10'd0);
        vt[14] = mk(0, 10'd0,    1, 1, 1,      1, 10'd1022, 0, 10'd0);
        vt[15] = mk(0, 10'd0,    1, 1, 1,      1, 10'd1023, 0, 10'd0);
        vt[16] = mk(0, 10'd0,    1, 1, 1,      1, 10'd0,    1, 10'd1022);
        vt[17] = mk(0, 10'd0,    1, 1, 1,      1, 10'd1,    1, 10'd1023);
        vt[18] = mk(0, 10'd0,    1, 1, 1,      1, 10'd2,    1, 10'd0);

        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #4;
        chk_zero("reset");
        tick();

        for (int i = 0; i < 19; i++) run_vec(vt[i], $sformatf("tbl c%0d", i));

        // Three fetches held in flight, then back-to-back redirects (0x0F0 then 0x100).
        // All three responses are dropped while draining; first delivered pc is 0x100.
        do_reset();
        run_vec(mk(0, 10'd0,     1, 0, 1, 1, 10'd0,     0, 10'd0),     "drain d0");
        run_vec(mk(0, 10'd0,     1, 0, 1, 1, 10'd1,     0, 10'd0),     "drain d1");
        run_vec(mk(0, 10'd0,     1, 0, 1, 1, 10'd2,     0, 10'd0),     "drain d2");
        run_vec(mk(1, 10'h0F0,   1, 0, 1, 0, 10'd3,     0, 10'd0),     "drain d3");
        run_vec(mk(1, 10'h100,   1, 1, 1, 0, 10'h0F0,   0, 10'd0),     "drain d4");
        run_vec(mk(0, 10'd0,     1, 1, 1, 0, 10'h100,   0, 10'd0),     "drain d5");
        run_vec(mk(0, 10'd0,     1, 1, 1, 0, 10'h100,   0, 10'd0),     "drain d6");
        run_vec(mk(0, 10'd0,     1, 1, 1, 1, 10'h100,   0, 10'd0),     "drain d7");
        run_vec(mk(0, 10'd0,     1, 1, 1, 1, 10'h101,   0, 10'd0),     "drain d8");
        run_vec(mk(0, 10'd0,     1, 1, 1, 1, 10'h102,   1, 10'h100),   "drain d9");
        run_vec(mk(0, 10'd0,     1, 1, 1, 1, 10'h103,   1, 10'h101),   "drain d10");

        // Fill to capacity (2 buffered + 2 in flight), reset, then feed the stale responses.
        do_reset();
        run_vec(mk(0, 10'd0, 1, 0, 0, 1, 10'd0, 0, 10'd0), "rst e0");
        run_vec(mk(0, 10'd0, 1, 0, 0, 1, 10'd1, 0, 10'd0), "rst e1");
        run_vec(mk(0, 10'd0, 1, 1, 0, 1, 10'd2, 0, 10'd0), "rst e2");
        run_vec(mk(0, 10'd0, 1, 1, 0, 1, 10'd3, 1, 10'd0), "rst e3");
        run_vec(mk(0, 10'd0, 1, 0, 0, 0, 10'd4, 1, 10'd0), "rst e4");
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        #4;
        chk_zero("rst hold");
        tick();
        run_vec(mk(0, 10'd0, 0, 1, 1, 1, 10'd0, 0, 10'd0), "rst e7");
        run_vec(mk(0, 10'd0, 0, 1, 1, 1, 10'd0, 0, 10'd0), "rst e8");
        run_vec(mk(0, 10'd0, 1, 1, 1, 1, 10'd0, 0, 10'd0), "rst e9");
        run_vec(mk(0, 10'd0, 1, 1, 1, 1, 10'd1, 0, 10'd0), "rst e10");
        run_vec(mk(0, 10'd0, 1, 1, 1, 1, 10'd2, 1, 10'd0), "rst e11");
        run_vec(mk(0, 10'd0, 1, 1, 1, 1, 10'd3, 1, 10'd1), "rst e12");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
